// File: rtl/result_streamer.sv
// Streams a block of result words out of the data memory over valid/ready.
// Reads are issued ahead of the consumer and buffered so backpressure never loses or repeats a word.
module result_streamer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int FIFO_D = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] addr_tb,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  // One extra slot holds the read that is already sitting in the memory's output
  // register when the issue check stops counting it as in flight.
  localparam int DEPTH = FIFO_D + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   issue_cnt, send_cnt;
  logic [1:0]        vld_pipe;   // [0]: address out this cycle, [1]: result valid this cycle
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     occ;
  logic              issue, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (occ != '0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (send_cnt == (ADDR_W+1)'(1));
  assign busy      = (state == RUN);
  assign done      = (state == FINISH);
  assign pop       = out_valid && out_ready;
  assign push      = vld_pipe[1];
  assign issue     = (state == RUN) && (issue_cnt != '0) &&
                     ((int'(occ) - int'(pop) + int'(vld_pipe[0])) < FIFO_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (word_count == '0) ? FINISH : RUN;
      RUN:     if (pop && send_cnt == (ADDR_W+1)'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      addr_tb   <= '0;
      issue_cnt <= '0;
      send_cnt  <= '0;
      vld_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], issue};
      if (state == IDLE && start) begin
        addr_q    <= base_addr;
        issue_cnt <= word_count;
        send_cnt  <= word_count;
      end else begin
        if (issue) begin
          addr_tb   <= addr_q;
          addr_q    <= addr_q + 1'b1;
          issue_cnt <= issue_cnt - 1'b1;
        end
        if (pop) send_cnt <= send_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= result;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_result_streamer.sv
// Randomized bench for result_streamer: a memory model plus an expected-word queue
// built directly from base/count, checked beat by beat.
module tb_result_streamer;
  logic        clk = 0;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] word_count;
  logic [11:0] addr_tb;
  logic [11:0] result;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [11:0] mem [4096];
  int checks = 0;
  int fails  = 0;
  bit pat [6] = '{1, 0, 0, 1, 0, 1};

  result_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .addr_tb(addr_tb), .result(result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) result <= mem[addr_tb];

  task automatic fill_mem(input bit incr);
    for (int k = 0; k < 4096; k++) mem[k] = incr ? 12'(k + 1) : 12'($urandom);
  endtask

  // mode 0: ready always high, 1: fixed 1,0,0,1,0,1 pattern, 2: random ready.
  // j counts edges since the one that sampled start (j=0 right after it).
  task automatic run_stream(input logic [11:0] b, input logic [12:0] n, input int mode,
                            input int restart_at);
    logic [11:0] expq [$];
    logic [11:0] held, exp_d;
    logic [11:0] exp_a;
    bit stalled, seen_done, rdy, exp_last;
    int j, beats, limit;
    for (int i = 0; i < int'(n); i++) expq.push_back(mem[(int'(b) + i) % 4096]);
    beats = 0; stalled = 0; seen_done = 0; held = '0;
    limit = 4 * int'(n) + 50;
    start = 1; base_addr = b; word_count = n;
    @(posedge clk); #1;
    start = 0; j = 0;
    while (!seen_done && j < limit) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[j % 6] : ($urandom_range(0, 2) != 0);
      out_ready = rdy;
      if (j == restart_at) begin
        start = 1; base_addr = b + 12'd100; word_count = 13'd3;
      end else start = 0;
      if (stalled) begin
        checks++;
        if (!out_valid || out_data !== held) begin
          fails++;
          $display("FAIL stall_hold j=%0d: valid=%0b data=%0h required valid=1 data=%0h",
                   j, out_valid, out_data, held);
        end
      end
      if (mode == 0 && j >= 1 && j <= int'(n)) begin
        exp_a = 12'((int'(b) + j - 1) % 4096);
        checks++;
        if (addr_tb !== exp_a) begin
          fails++;
          $display("FAIL addr_seq j=%0d: got %0d required %0d", j, addr_tb, exp_a);
        end
      end
      if (mode == 0 && j == 3 && n != 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          fails++;
          $display("FAIL first_latency: out_valid=%0b at edge 3, required 1", out_valid);
        end
      end
      if (out_valid) begin
        if (rdy) begin
          checks++;
          if (expq.size() == 0) begin
            fails++;
            $display("FAIL extra_beat j=%0d: got data %0h, required no beat", j, out_data);
          end else begin
            exp_d = expq.pop_front();
            exp_last = (beats == int'(n) - 1);
            if (out_data !== exp_d || out_last !== exp_last) begin
              fails++;
              $display("FAIL beat%0d: data=%0h last=%0b required data=%0h last=%0b",
                       beats, out_data, out_last, exp_d, exp_last);
            end
          end
          beats++;
        end
        stalled = !rdy;
        held = out_data;
      end else stalled = 0;
      if (done) begin
        seen_done = 1;
        checks++;
        if (beats != int'(n) || busy !== 1'b0) begin
          fails++;
          $display("FAIL done_count: beats=%0d busy=%0b required beats=%0d busy=0",
                   beats, busy, n);
        end
        if (mode == 0) begin
          checks++;
          if (j != ((n == 0) ? 0 : int'(n) + 3)) begin
            fails++;
            $display("FAIL done_time: done at edge %0d required %0d", j,
                     (n == 0) ? 0 : int'(n) + 3);
          end
        end
      end
      @(posedge clk); #1;
      j++;
    end
    start = 0;
    if (!seen_done) begin
      checks++; fails++;
      $display("FAIL done_timeout: no done within %0d cycles, beats=%0d", limit, beats);
    end
  endtask

  task automatic test_reset;
    rst_n = 0; start = 0; base_addr = '0; word_count = '0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({addr_tb, out_data, out_valid, out_last, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_state: addr=%0h data=%0h v=%0b l=%0b busy=%0b done=%0b required all 0",
               addr_tb, out_data, out_valid, out_last, busy, done);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    fill_mem(1);
    run_stream(12'd8, 13'd4, 0, -1);
    checks++;
    if (addr_tb !== 12'd11) begin
      fails++;
      $display("FAIL addr_hold: got %0d required 11", addr_tb);
    end
  endtask

  task automatic test_backpressure;
    fill_mem(1);
    run_stream(12'd8, 13'd4, 1, -1);
    fill_mem(0);
    run_stream(12'($urandom), 13'd16, 2, -1);
    run_stream(12'($urandom), 13'd9, 1, -1);
  endtask

  task automatic test_wrap;
    fill_mem(0);
    run_stream(12'd4094, 13'd4, 0, -1);
  endtask

  task automatic test_zero_and_ignore;
    logic [11:0] b;
    fill_mem(0);
    run_stream(12'($urandom), 13'd0, 0, 0);  // start also pulsed in the FINISH cycle
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL finish_start k=%0d: busy=%0b valid=%0b required 0 0", k, busy, out_valid);
      end
      @(posedge clk); #1;
    end
    b = 12'($urandom);
    run_stream(b, 13'd16, 0, 5);
  endtask

  task automatic test_reset_mid;
    int beats, j;
    fill_mem(0);
    out_ready = 1;
    start = 1; base_addr = 12'($urandom); word_count = 13'd8;
    @(posedge clk); #1;
    start = 0; beats = 0; j = 0;
    while (beats < 2 && j < 20) begin
      if (out_valid && out_ready) beats++;
      @(posedge clk); #1;
      j++;
    end
    checks++;
    if (beats != 2) begin
      fails++;
      $display("FAIL mid_beats: got %0d beats required 2", beats);
    end
    rst_n = 0; #1;
    checks++;
    if ({addr_tb, out_data, out_valid, out_last, busy, done} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: addr=%0h data=%0h v=%0b busy=%0b done=%0b required all 0",
               addr_tb, out_data, out_valid, busy, done);
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL mid_no_done k=%0d: done=%0b valid=%0b required 0 0", k, done, out_valid);
      end
      @(posedge clk); #1;
    end
    run_stream(12'd0, 13'd2, 0, -1);
  endtask

  task automatic test_full;
    fill_mem(0);
    run_stream(12'd0, 13'd4096, 0, -1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_zero_and_ignore;
    test_reset_mid;
    test_full;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
